// File: rtl/ddr_to_rgb.sv
// Frame reader: pulls 64-word bursts of stored pixels from MCB read port p1
// and pushes them into the display-side pixel FIFO, one command in flight at a time.
module ddr_to_rgb #(
    parameter int          RGB_WIDTH        = 24,
    parameter int          DATA_COUNT_WIDTH = 11,
    parameter int          FIFO_DEPTH       = 2048,
    parameter int          PIXEL_COUNT      = 4096,
    parameter logic [29:0] BASE_ADDR        = 30'h0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        c3_calib_done,
    input  logic                        frame_start,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        error,
    output logic                        c3_p1_cmd_en,
    output logic [2:0]                  c3_p1_cmd_instr,
    output logic [5:0]                  c3_p1_cmd_bl,
    output logic [29:0]                 c3_p1_cmd_byte_addr,
    input  logic                        c3_p1_cmd_full,
    output logic                        c3_p1_rd_en,
    input  logic [31:0]                 c3_p1_rd_data,
    input  logic                        c3_p1_rd_empty,
    input  logic                        c3_p1_rd_overflow,
    input  logic                        c3_p1_rd_error,
    output logic [RGB_WIDTH-1:0]        fifo_data_in,
    output logic                        fifo_write_enable,
    input  logic [DATA_COUNT_WIDTH-1:0] fifo_wr_data_count,
    input  logic                        fifo_full,
    output logic [7:0]                  led
);

    localparam int BURSTS = PIXEL_COUNT / 64;
    localparam int BC_W   = $clog2(BURSTS + 1);
    localparam logic [BC_W-1:0] LAST_BURST = BC_W'(BURSTS);
    // Room for a whole burst plus two words of slack for the count's update lag.
    localparam logic [DATA_COUNT_WIDTH-1:0] SPACE_LIMIT = DATA_COUNT_WIDTH'(FIFO_DEPTH - 66);

    typedef enum logic [2:0] {
        WAIT_CALIB,
        IDLE,
        WAIT_SPACE,
        ISSUE,
        READ,
        CHECK
    } state_t;

    state_t          state;
    logic [29:0]     addr;
    logic [BC_W-1:0] burst_cnt;
    logic [6:0]      word_cnt;
    logic [7:0]      frame_cnt;
    logic            calib_q;
    logic            pop;
    logic            unused_rd_bits;

    assign unused_rd_bits = ^c3_p1_rd_data[31:RGB_WIDTH];

    assign c3_p1_cmd_instr = 3'b011;
    assign c3_p1_cmd_bl    = 6'd63;

    assign pop = (state == READ) && !c3_p1_rd_empty && (word_cnt < 7'd64) && !fifo_full;
    assign c3_p1_rd_en = pop;

    assign led = {frame_cnt[4:0], error, busy, calib_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= WAIT_CALIB;
            addr                <= BASE_ADDR;
            burst_cnt           <= '0;
            word_cnt            <= '0;
            frame_cnt           <= '0;
            calib_q             <= 1'b0;
            busy                <= 1'b0;
            error               <= 1'b0;
            frame_done          <= 1'b0;
            c3_p1_cmd_en        <= 1'b0;
            c3_p1_cmd_byte_addr <= '0;
            fifo_write_enable   <= 1'b0;
            fifo_data_in        <= '0;
        end else begin
            c3_p1_cmd_en <= 1'b0;
            frame_done   <= 1'b0;
            calib_q      <= c3_calib_done;
            error        <= error | c3_p1_rd_overflow | c3_p1_rd_error;

            // pop -> push stage: the popped word lands in the pixel FIFO next cycle
            fifo_write_enable <= pop;
            if (pop) begin
                fifo_data_in <= c3_p1_rd_data[RGB_WIDTH-1:0];
            end

            case (state)
                WAIT_CALIB: begin
                    if (c3_calib_done) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (frame_start) begin
                        busy      <= 1'b1;
                        addr      <= BASE_ADDR;
                        burst_cnt <= '0;
                        state     <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (fifo_wr_data_count <= SPACE_LIMIT) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!c3_p1_cmd_full) begin
                        c3_p1_cmd_en        <= 1'b1;
                        c3_p1_cmd_byte_addr <= addr;
                        addr                <= addr + 30'd256;
                        state               <= READ;
                    end
                end
                READ: begin
                    if (pop) begin
                        if (word_cnt == 7'd63) begin
                            word_cnt  <= '0;
                            burst_cnt <= burst_cnt + 1'b1;
                            state     <= CHECK;
                        end else begin
                            word_cnt <= word_cnt + 7'd1;
                        end
                    end
                end
                CHECK: begin
                    if (burst_cnt == LAST_BURST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        frame_cnt  <= frame_cnt + 8'd1;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT_SPACE;
                    end
                end
                default: state <= WAIT_CALIB;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_to_rgb.sv
// Directed bench for ddr_to_rgb with a small MCB read-port model and a
// push/pop monitor; each scenario task checks its own expectations.
module tb_ddr_to_rgb;

    logic        clk = 1'b0;
    logic        rst;
    logic        c3_calib_done;
    logic        frame_start;
    logic        frame_done;
    logic        busy;
    logic        error;
    logic        c3_p1_cmd_en;
    logic [2:0]  c3_p1_cmd_instr;
    logic [5:0]  c3_p1_cmd_bl;
    logic [29:0] c3_p1_cmd_byte_addr;
    logic        c3_p1_cmd_full;
    logic        c3_p1_rd_en;
    logic [31:0] c3_p1_rd_data = 32'h0;
    logic        c3_p1_rd_empty = 1'b1;
    logic        c3_p1_rd_overflow;
    logic        c3_p1_rd_error;
    logic [23:0] fifo_data_in;
    logic        fifo_write_enable;
    logic [10:0] fifo_wr_data_count;
    logic        fifo_full;
    logic [7:0]  led;

    always #5 clk = ~clk;

    ddr_to_rgb #(
        .RGB_WIDTH(24),
        .DATA_COUNT_WIDTH(11),
        .FIFO_DEPTH(2048),
        .PIXEL_COUNT(256),
        .BASE_ADDR(30'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .c3_calib_done(c3_calib_done),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .busy(busy),
        .error(error),
        .c3_p1_cmd_en(c3_p1_cmd_en),
        .c3_p1_cmd_instr(c3_p1_cmd_instr),
        .c3_p1_cmd_bl(c3_p1_cmd_bl),
        .c3_p1_cmd_byte_addr(c3_p1_cmd_byte_addr),
        .c3_p1_cmd_full(c3_p1_cmd_full),
        .c3_p1_rd_en(c3_p1_rd_en),
        .c3_p1_rd_data(c3_p1_rd_data),
        .c3_p1_rd_empty(c3_p1_rd_empty),
        .c3_p1_rd_overflow(c3_p1_rd_overflow),
        .c3_p1_rd_error(c3_p1_rd_error),
        .fifo_data_in(fifo_data_in),
        .fifo_write_enable(fifo_write_enable),
        .fifo_wr_data_count(fifo_wr_data_count),
        .fifo_full(fifo_full),
        .led(led)
    );

    int errors = 0;
    int checks = 0;

    // MCB read port model: a command queues 64 words whose value is the word index
    int rdq[$];
    bit gap_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            rdq.delete();
        end else begin
            if (c3_p1_rd_en && rdq.size() > 0) void'(rdq.pop_front());
            if (c3_p1_cmd_en) begin
                for (int i = 0; i < 64; i++) rdq.push_back(int'(c3_p1_cmd_byte_addr >> 2) + i);
            end
        end
        c3_p1_rd_empty <= (rdq.size() == 0) || (gap_en && ($urandom_range(0, 1) == 1));
        c3_p1_rd_data  <= (rdq.size() > 0) ? {8'hA5, 24'(rdq[0])} : 32'h0;
    end

    // Monitor, sampled on the falling edge
    int          push_cnt, push_bad, lag_bad, pop_cnt, popfull_bad;
    int          cmd_cnt, cmd_long, done_cnt, exp_next;
    logic        prev_pop = 1'b0;
    logic        prev_cmd = 1'b0;
    logic [23:0] prev_data = '0;
    logic [29:0] cmd_addrs[$];

    always @(negedge clk) begin
        if (fifo_write_enable) begin
            push_cnt++;
            if (fifo_data_in !== exp_next[23:0]) push_bad++;
            exp_next++;
        end
        if (!rst) begin
            if (fifo_write_enable !== prev_pop || (prev_pop && fifo_data_in !== prev_data)) lag_bad++;
            prev_pop  = c3_p1_rd_en;
            prev_data = c3_p1_rd_data[23:0];
        end else begin
            prev_pop = 1'b0;
        end
        if (c3_p1_rd_en) begin
            pop_cnt++;
            if (fifo_full) popfull_bad++;
        end
        if (c3_p1_cmd_en) begin
            cmd_cnt++;
            cmd_addrs.push_back(c3_p1_cmd_byte_addr);
            if (prev_cmd) cmd_long++;
        end
        prev_cmd = c3_p1_cmd_en;
        if (frame_done) done_cnt++;
    end

    task automatic clear_counters();
        push_cnt = 0; push_bad = 0; lag_bad = 0; pop_cnt = 0; popfull_bad = 0;
        cmd_cnt = 0; cmd_long = 0; done_cnt = 0; exp_next = 0;
        cmd_addrs.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_pops(input int n, output bit got);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (pop_cnt >= n) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; c3_calib_done = 1'b0; frame_start = 1'b0; c3_p1_cmd_full = 1'b0;
        c3_p1_rd_overflow = 1'b0; c3_p1_rd_error = 1'b0; fifo_wr_data_count = '0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (c3_p1_cmd_en !== 1'b0) begin errors++; $display("FAIL reset_cmd_en got=%0b exp=0", c3_p1_cmd_en); end
        checks++; if (c3_p1_cmd_instr !== 3'b011) begin errors++; $display("FAIL reset_instr got=%0b exp=011", c3_p1_cmd_instr); end
        checks++; if (c3_p1_cmd_bl !== 6'd63) begin errors++; $display("FAIL reset_bl got=%0d exp=63", c3_p1_cmd_bl); end
        checks++; if ({busy, error, frame_done, c3_p1_rd_en, fifo_write_enable} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%05b exp=00000", {busy, error, frame_done, c3_p1_rd_en, fifo_write_enable});
        end
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got=%0h exp=0", led); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_calib_gating();
        bit seen = 1'b0;
        clear_counters();
        pulse_start();
        repeat (20) @(negedge clk);
        checks++; if (cmd_cnt !== 0) begin errors++; $display("FAIL nocalib_cmds got=%0d exp=0", cmd_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nocalib_busy got=%0b exp=0", busy); end
        @(posedge clk); #1 c3_calib_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL calib_led0 got=%0b exp=1", led[0]); end
        pulse_start();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (c3_p1_cmd_en) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL first_cmd got=none exp=cmd_en"); end
        checks++; if (c3_p1_cmd_byte_addr !== 30'h0 || c3_p1_cmd_instr !== 3'b011 || c3_p1_cmd_bl !== 6'd63) begin
            errors++; $display("FAIL first_cmd_fields got=%0h/%0b/%0d exp=0/011/63", c3_p1_cmd_byte_addr, c3_p1_cmd_instr, c3_p1_cmd_bl);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_cmd_busy got=%0b exp=1", busy); end
    endtask

    task automatic test_full_frame();
        bit got;
        wait_done(got);
        checks++; if (!got) begin errors++; $display("FAIL frame_done got=timeout exp=pulse"); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after got=%0b exp=0", busy); end
        checks++; if (cmd_cnt !== 4 || cmd_long !== 0) begin errors++; $display("FAIL cmd_count got=%0d long=%0d exp=4 long=0", cmd_cnt, cmd_long); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_addrs.size() <= i || cmd_addrs[i] !== 30'(i * 256)) begin
                errors++; $display("FAIL cmd_addr%0d got=%0h exp=%0h", i, (cmd_addrs.size() > i) ? cmd_addrs[i] : 30'h3fffffff, i * 256);
            end
        end
        checks++; if (push_cnt !== 256 || push_bad !== 0 || lag_bad !== 0) begin
            errors++; $display("FAIL pushes got=%0d bad=%0d lag=%0d exp=256 bad=0 lag=0", push_cnt, push_bad, lag_bad);
        end
    endtask

    task automatic test_backpressure();
        bit got;
        bit seen = 1'b0;
        clear_counters();
        fifo_wr_data_count = 11'd2000;
        pulse_start();
        repeat (20) @(negedge clk);
        checks++; if (cmd_cnt !== 0 || busy !== 1'b1) begin errors++; $display("FAIL bp_2000 got=cmds %0d busy %0b exp=cmds 0 busy 1", cmd_cnt, busy); end
        @(posedge clk); #1 fifo_wr_data_count = 11'd1983;
        repeat (10) @(negedge clk);
        checks++; if (cmd_cnt !== 0) begin errors++; $display("FAIL bp_1983 got=%0d exp=0", cmd_cnt); end
        @(posedge clk); #1 fifo_wr_data_count = 11'd1982;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            if (c3_p1_cmd_en) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_1982 got=no cmd exp=cmd within 2 cycles"); end
        fifo_wr_data_count = 11'd0;
        wait_done(got);
        checks++; if (!got || push_cnt !== 256 || push_bad !== 0 || cmd_cnt !== 4) begin
            errors++; $display("FAIL bp_frame got=done %0b pushes %0d bad %0d cmds %0d exp=1 256 0 4", got, push_cnt, push_bad, cmd_cnt);
        end
    endtask

    task automatic test_cmd_full();
        bit got;
        clear_counters();
        pulse_start();
        wait_pops(64, got);
        @(posedge clk); #1 c3_p1_cmd_full = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (cmd_cnt !== 1) begin errors++; $display("FAIL cmdfull_hold got=%0d exp=1", cmd_cnt); end
        @(posedge clk); #1 c3_p1_cmd_full = 1'b0;
        wait_done(got);
        checks++; if (!got || cmd_cnt !== 4 || cmd_long !== 0) begin
            errors++; $display("FAIL cmdfull_frame got=done %0b cmds %0d long %0d exp=1 4 0", got, cmd_cnt, cmd_long);
        end
        checks++; if (cmd_addrs.size() < 3 || cmd_addrs[1] !== 30'd256 || cmd_addrs[2] !== 30'd512) begin
            errors++; $display("FAIL cmdfull_addr got=%0h,%0h exp=100,200", (cmd_addrs.size() > 1) ? cmd_addrs[1] : 30'h0, (cmd_addrs.size() > 2) ? cmd_addrs[2] : 30'h0);
        end
        checks++; if (push_cnt !== 256 || push_bad !== 0) begin errors++; $display("FAIL cmdfull_data got=%0d bad=%0d exp=256 bad=0", push_cnt, push_bad); end
    endtask

    task automatic test_gapped();
        bit got;
        int p0;
        clear_counters();
        gap_en = 1'b1;
        pulse_start();
        wait_pops(100, got);
        @(posedge clk); #1 fifo_full = 1'b1;
        p0 = pop_cnt;
        repeat (5) @(negedge clk);
        checks++; if (pop_cnt !== p0 || popfull_bad !== 0) begin
            errors++; $display("FAIL full_no_pop got=%0d pops while full exp=0", pop_cnt - p0 + popfull_bad);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        wait_done(got);
        gap_en = 1'b0;
        checks++; if (!got || pop_cnt !== 256 || push_cnt !== 256) begin
            errors++; $display("FAIL gapped_count got=done %0b pops %0d pushes %0d exp=1 256 256", got, pop_cnt, push_cnt);
        end
        checks++; if (push_bad !== 0 || lag_bad !== 0) begin errors++; $display("FAIL gapped_order got=bad %0d lag %0d exp=0 0", push_bad, lag_bad); end
    endtask

    task automatic test_error();
        bit got;
        clear_counters();
        pulse_start();
        wait_pops(30, got);
        @(posedge clk); #1 c3_p1_rd_error = 1'b1;
        @(posedge clk); #1 c3_p1_rd_error = 1'b0;
        @(negedge clk);
        checks++; if (error !== 1'b1 || led[2] !== 1'b1) begin errors++; $display("FAIL error_set got=%0b/%0b exp=1/1", error, led[2]); end
        wait_done(got);
        checks++; if (!got || push_cnt !== 256) begin errors++; $display("FAIL error_frame got=done %0b pushes %0d exp=1 256", got, push_cnt); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_sticky got=%0b exp=1", error); end
        checks++; if (led[7:3] !== 5'd5) begin errors++; $display("FAIL frame_counter got=%0d exp=5", led[7:3]); end
    endtask

    task automatic test_reset_mid_burst();
        bit got;
        int p0;
        clear_counters();
        pulse_start();
        wait_pops(10, got);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({c3_p1_cmd_en, c3_p1_rd_en, fifo_write_enable, busy, error, frame_done} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_flags got=%06b exp=000000", {c3_p1_cmd_en, c3_p1_rd_en, fifo_write_enable, busy, error, frame_done});
        end
        checks++; if (led !== 8'h00 || fifo_data_in !== 24'h0 || c3_p1_cmd_byte_addr !== 30'h0) begin
            errors++; $display("FAIL rst_mid_outs got=led %0h data %0h addr %0h exp=0 0 0", led, fifo_data_in, c3_p1_cmd_byte_addr);
        end
        p0 = push_cnt;
        repeat (5) @(negedge clk);
        checks++; if (push_cnt !== p0) begin errors++; $display("FAIL rst_hold_push got=%0d exp=%0d", push_cnt, p0); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_counters();
        pulse_start();
        wait_done(got);
        checks++; if (!got || push_cnt !== 256 || push_bad !== 0 || cmd_cnt !== 4) begin
            errors++; $display("FAIL after_rst_frame got=done %0b pushes %0d bad %0d cmds %0d exp=1 256 0 4", got, push_cnt, push_bad, cmd_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counters();
        test_reset();
        test_calib_gating();
        test_full_frame();
        test_backpressure();
        test_cmd_full();
        test_gapped();
        test_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
